// File: rtl/seg_display_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_pkg
// Shared definitions for the binary-to-BCD converter and the 4-digit
// seven-segment display multiplexer it feeds.
//   - BCD_DIGIT_W      : width of one packed BCD digit
//   - DEF_*            : default sizing shared by converter and display
//   - conv_state_e     : converter FSM state encoding
//   - bcd_all_nines()  : saturated all-9 BCD pattern for N digits
// ---------------------------------------------------------------------------
package seg_display_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int DEF_DIGITS     = 4;
  localparam int DEF_MAX_VAL    = 9999;
  localparam int DEF_BIN_W      = 14;
  // Widest display the saturation helper can describe.
  localparam int MAX_SAT_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Returns the low n digits set to 9, upper digits zero.
  function automatic logic [MAX_SAT_DIGITS*BCD_DIGIT_W-1:0] bcd_all_nines(
    input int unsigned n
  );
    logic [MAX_SAT_DIGITS*BCD_DIGIT_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_SAT_DIGITS; k++) begin
      if (k < int'(n)) r[k*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Start/done handshake and result bus of the binary-to-BCD converter.
//   start  : conversion request (master -> slave)
//   bin    : binary operand, sampled on the accepting edge (master -> slave)
//   busy   : conversion in progress (slave -> master)
//   done   : one-cycle pulse when bcd/ovf update (slave -> master)
//   bcd    : packed BCD result, digit k at [4k+3:4k] (slave -> master)
//   ovf    : last accepted operand exceeded MAX_VAL (slave -> master)
// ---------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = seg_display_pkg::DEF_BIN_W,
  parameter int DIGITS = seg_display_pkg::DEF_DIGITS
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bcd_add3_digit.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next digit.
//   i_digit : digit before correction
//   o_digit : corrected digit (4-bit add, no carry out)
// ---------------------------------------------------------------------------
module bcd_add3_digit
  import seg_display_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (iterative shift-add-3). One operand
// bit is shifted per cycle; the published result only changes on the edge
// that finishes a conversion, so the display never sees partial values.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bin_to_bcd_seq_if (start/bin in, busy/done/bcd/ovf out)
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import seg_display_pkg::*;
#(
  parameter int BIN_W   = DEF_BIN_W,
  parameter int DIGITS  = DEF_DIGITS,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [BCD_W-1:0] SAT_BCD  = BCD_W'(bcd_all_nines(DIGITS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  conv_state_e        r_state;
  logic [SH_W-1:0]    r_sh;        // {BCD field, remaining operand bits}
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;  // overflow of the operand being converted
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic [BCD_W-1:0]   w_bcd_adj;
  logic [SH_W-1:0]    w_sh_next;
  logic [BCD_W-1:0]   w_bcd_final;
  logic               w_last;
  logic               w_in_ovf;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3_digit u_add3 (
      .i_digit (r_sh[BIN_W + k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_bcd_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct every digit first, then shift the whole register left by one.
  assign w_sh_next   = {w_bcd_adj[BCD_W-2:0], r_sh[BIN_W-1:0], 1'b0};
  // On the final shift the BCD field of w_sh_next is the complete result.
  assign w_bcd_final = w_sh_next[SH_W-1:BIN_W];
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_in_ovf    = (int'(bus.bin) > MAX_VAL);

  // NOTE: every register here, the datapath shift register included, is
  // reset so an aborted conversion leaves no stale state behind, and all
  // sequential updates use <= so each branch sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state    <= SHIFT;
            r_sh       <= SH_W'(bus.bin);
            r_cnt      <= '0;
            r_ovf_pend <= w_in_ovf;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here: no queueing.
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= r_ovf_pend ? SAT_BCD : w_bcd_final;
            r_ovf   <= r_ovf_pend;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed-vector and random bench for bin_to_bcd_seq at default sizing
// (BIN_W=14, DIGITS=4, MAX_VAL=9999). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;
  localparam int LAT     = BIN_W + 1;

  logic clk;
  logic rst_n;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] last_bcd = 16'h0000;
  logic        last_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digit extraction with saturation, returns {ovf, bcd}.
  function automatic logic [16:0] ref_conv(input int unsigned v);
    logic [15:0] r;
    int unsigned d;
    if (v > MAX_VAL) return {1'b1, 16'h9999};
    r = '0;
    d = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return {1'b0, r};
  endfunction

  // Waits (bounded) for done; reports cycles since acceptance, whether busy
  // dropped early and whether bcd/ovf moved before done.
  task automatic wait_done(output int n, output bit busy_bad, output bit stable_bad);
    n = 0;
    busy_bad = 0;
    stable_bad = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (!bus.busy) busy_bad = 1;
      if (bus.bcd !== last_bcd || bus.ovf !== last_ovf) stable_bad = 1;
    end
  endtask

  task automatic run_conv(input logic [BIN_W-1:0] b, input logic [15:0] eb,
                          input logic eo, input string nm);
    int n;
    bit busy_bad, stable_bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = ~b;  // must not affect the result
    wait_done(n, busy_bad, stable_bad);
    check({nm, " latency"}, n, LAT);
    check({nm, " busy"}, {31'd0, busy_bad}, 0);
    check({nm, " stable"}, {31'd0, stable_bad}, 0);
    check({nm, " bcd"}, bus.bcd, eb);
    check({nm, " ovf"}, bus.ovf, eo);
    check({nm, " busy_in_done"}, bus.busy, 0);
    last_bcd = eb;
    last_ovf = eo;
    @(negedge clk);
    check({nm, " done_pulse"}, bus.done, 0);
  endtask

  typedef struct {
    string            name;
    logic [BIN_W-1:0] bin;
    logic [15:0]      bcd;
    logic             ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    bit busy_bad, stable_bad;
    int done_seen;
    logic [16:0] r;
    logic [BIN_W-1:0] rb;

    vecs[0] = '{"v1234",  14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{"v0",     14'd0,     16'h0000, 1'b0};
    vecs[2] = '{"v9",     14'd9,     16'h0009, 1'b0};
    vecs[3] = '{"v10",    14'd10,    16'h0010, 1'b0};
    vecs[4] = '{"v9999",  14'd9999,  16'h9999, 1'b0};
    vecs[5] = '{"v10000", 14'd10000, 16'h9999, 1'b1};
    vecs[6] = '{"v42",    14'd42,    16'h0042, 1'b0};

    // Reset state.
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst bcd", bus.bcd, 16'h0000);
    check("rst ovf", bus.ovf, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);

    // Directed vectors.
    foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].name);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'd1234;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst bcd", bus.bcd, 16'h0000);
    check("midrst ovf", bus.ovf, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("midrst no_done", done_seen, 0);
    last_bcd = 16'h0000;
    last_ovf = 1'b0;

    // start held while busy, operand changed after acceptance.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 14'd321;
    @(posedge clk);
    #1 bus.bin = 14'd5678;
    wait_done(n, busy_bad, stable_bad);
    check("hold latency", n, LAT);
    check("hold busy", {31'd0, busy_bad}, 0);
    check("hold stable", {31'd0, stable_bad}, 0);
    check("hold bcd", bus.bcd, 16'h0321);
    check("hold ovf", bus.ovf, 0);
    last_bcd = 16'h0321;

    // start still high in the DONE cycle: back-to-back conversion.
    bus.bin = 14'd777;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = '0;
    wait_done(n, busy_bad, stable_bad);
    check("b2b latency", n, LAT);
    check("b2b busy", {31'd0, busy_bad}, 0);
    check("b2b stable", {31'd0, stable_bad}, 0);
    check("b2b bcd", bus.bcd, 16'h0777);
    check("b2b ovf", bus.ovf, 0);
    last_bcd = 16'h0777;
    last_ovf = 1'b0;
    @(negedge clk);
    check("b2b done_pulse", bus.done, 0);

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      rb = BIN_W'($urandom_range(0, 16383));
      r  = ref_conv(int'(rb));
      run_conv(rb, r[15:0], r[16], "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
